// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake and result bus between a requester and the bin2bcd_seq converter.
// The blank vector exists only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_seq_if #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [DIGITS*4-1:0]   bcd;
    logic                  ovf;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;

    modport master (output start, bin, input busy, done, bcd, ovf, blank);
    modport slave  (input start, bin, output busy, done, bcd, ovf, blank);
`else
    modport master (output start, bin, input busy, done, bcd, ovf);
    modport slave  (input start, bin, output busy, done, bcd, ovf);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock, saturating at 10^DIGITS-1.
// Optional leading-zero blanking vector enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic          clk,
    input  logic          nrst,
    bin2bcd_seq_if.slave  bus
);

    // Number of decimal digits needed to hold 2^bits-1.
    function automatic int unsigned dec_digits(input int unsigned bits);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << bits) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam int unsigned     BCD_W   = DIGITS * 4;
    localparam int unsigned     SCR_DIG = (dec_digits(BIN_W) > DIGITS) ? dec_digits(BIN_W) : DIGITS;
    localparam int unsigned     SCR_W   = SCR_DIG * 4;
    localparam int unsigned     CNT_W   = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic [SCR_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               hi_zero;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            sh_q       <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef BIN2BCD_BLANK_EN
            blank_q    <= blank_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        adj        = scr_q;
`ifdef BIN2BCD_BLANK_EN
        blank_d    = blank_q;
        hi_zero    = 1'b1;
`endif

        // Pre-shift correction: any nibble >= 5 would exceed 9 after doubling.
        for (int unsigned i = 0; i < SCR_DIG; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sh_d       = bus.bin;
                    scr_d      = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = 64'(bus.bin) > MAX_VAL;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {scr_d, sh_d} = {adj, sh_q} << 1;
                cnt_d         = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                ovf_d   = ovf_pend_q;
                bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scr_q[BCD_W-1:0];
`ifdef BIN2BCD_BLANK_EN
                // A digit is blank when it and every more significant digit are zero.
                blank_d = '0;
                for (int i = DIGITS - 1; i >= 1; i--) begin
                    hi_zero    = hi_zero && (scr_q[4*i +: 4] == 4'd0);
                    blank_d[i] = hi_zero && !ovf_pend_q;
                end
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_SHIFT);
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.bcd   = bcd_q;
    assign bus.ovf   = ovf_q;
`ifdef BIN2BCD_BLANK_EN
    assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against a decimal-arithmetic reference model.
// Blank checks are compiled in when BIN2BCD_BLANK_EN is defined.
module tb_bin2bcd_seq;

    localparam int unsigned BIN_W  = 14;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned BCD_W  = DIGITS * 4;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [BCD_W-1:0] held_bcd;
    logic             held_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned max_val();
        int unsigned r = 1;
        for (int i = 0; i < DIGITS; i++) r = r * 10;
        return r - 1;
    endfunction

    function automatic logic [BCD_W-1:0] model_bcd(input int unsigned v);
        logic [BCD_W-1:0] r;
        int unsigned t;
        r = '0;
        t = v;
        if (v > max_val()) begin
            for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = 4'h9;
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                r[4*d +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] model_blank(input int unsigned v);
        logic [DIGITS-1:0] b;
        int unsigned nd, t;
        b  = '0;
        nd = 1;
        t  = v;
        while (t >= 10) begin
            t  = t / 10;
            nd = nd + 1;
        end
        if (v <= max_val())
            for (int i = 1; i < DIGITS; i++) b[i] = (i >= nd);
        return b;
    endfunction

    // Runs one conversion with exact-latency checks; optionally pokes start mid-SHIFT.
    task automatic convert(input int unsigned v, input bit poke);
        bus.start = 1'b1;
        bus.bin   = BIN_W'(v);
        @(negedge clk);
        bus.bin   = BIN_W'($urandom);
        for (int k = 1; k <= BIN_W; k++) begin
            check($sformatf("busy_c%0d_v%0d", k, v), 64'(bus.busy), 64'd1);
            check($sformatf("done_lo_c%0d_v%0d", k, v), 64'(bus.done), 64'd0);
            if (k == 1 || k == BIN_W)
                check($sformatf("bcd_held_c%0d_v%0d", k, v), 64'(bus.bcd), 64'(held_bcd));
            bus.start = poke && (k == 5);
            if (poke && k == 5) bus.bin = BIN_W'(5);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check($sformatf("busy_end_v%0d", v), 64'(bus.busy), 64'd0);
        check($sformatf("done_early_v%0d", v), 64'(bus.done), 64'd0);
        @(negedge clk);
        check($sformatf("done_v%0d", v), 64'(bus.done), 64'd1);
        check($sformatf("bcd_v%0d", v), 64'(bus.bcd), 64'(model_bcd(v)));
        check($sformatf("ovf_v%0d", v), 64'(bus.ovf), 64'(v > max_val()));
`ifdef BIN2BCD_BLANK_EN
        check($sformatf("blank_v%0d", v), 64'(bus.blank), 64'(model_blank(v)));
`endif
        held_bcd = model_bcd(v);
        held_ovf = (v > max_val());
        @(negedge clk);
        check($sformatf("done_pulse_v%0d", v), 64'(bus.done), 64'd0);
        check($sformatf("bcd_hold_v%0d", v), 64'(bus.bcd), 64'(held_bcd));
        check($sformatf("busy_idle_v%0d", v), 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int unsigned dir [10] = '{1234, 9999, 10000, 0, 42, 1000, 12000, 16383, 1, 9};
        bit saw_done;

        nrst      = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        held_bcd  = '0;
        held_ovf  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd",  64'(bus.bcd),  64'd0);
        check("rst_ovf",  64'(bus.ovf),  64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
`ifdef BIN2BCD_BLANK_EN
        check("rst_blank", 64'(bus.blank), 64'd0);
`endif
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_done", 64'(bus.done), 64'd0);

        foreach (dir[i]) convert(dir[i], 1'b0);
        convert(1234, 1'b1);
        for (int i = 0; i < 25; i++) convert($urandom_range(0, (1 << BIN_W) - 1), ($urandom_range(0, 3) == 0));

        // Reset in the middle of a conversion aborts it silently.
        bus.start = 1'b1;
        bus.bin   = BIN_W'(1234);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("midrst_bcd",  64'(bus.bcd),  64'd0);
        check("midrst_ovf",  64'(bus.ovf),  64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        held_bcd = '0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        check("midrst_no_done", 64'(saw_done), 64'd0);
        convert(42, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
